dsp_filter_ctrl: RTL and testbench

DSP_FILTER_CTRL -- requirements
Module: dsp_filter_ctrl

---
 rtl/dsp_filter_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dsp_filter_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_filter_ctrl.sv
`timescale 1ns/1ps
// Purpose : frame sequencer around an external fixed-latency filter (flush, stream, drain, done).
// Latency : in_data -> filt_x 1 edge; accepting edge -> out_valid LAT+1 edges.
// Backpr. : in_ready high only in RUN; no output backpressure, results stream out as produced.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, abort        one-cycle frame request / abandon current frame
//   in_valid, in_data,  sample input handshake
//   in_ready
//   filt_x, filt_rst_n  drive side of the external filter
//   filt_y              filter result, valid LAT edges after filt_x
//   out_valid, out_data,
//   out_last            filtered sample stream, out_last on the FRAME_LEN-th output
//   busy, done          not-idle flag, one-cycle completion pulse
module dsp_filter_ctrl #(
  parameter int N         = 7,
  parameter int LAT       = 1,
  parameter int FRAME_LEN = 100,
  parameter int FLUSH_LEN = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         in_valid,
  input  logic [N:0]   in_data,
  output logic         in_ready,
  output logic [N:0]   filt_x,
  output logic         filt_rst_n,
  input  logic [N:0]   filt_y,
  output logic         out_valid,
  output logic [N:0]   out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int FW = $clog2(FLUSH_LEN + 1);

  typedef enum logic [2:0] {IDLE, FLUSH, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [FW-1:0] flush_cnt;
  logic          aborting;   // current FLUSH is the post-abort flush, ends in IDLE
  logic [CW-1:0] acc_cnt;
  logic [CW-1:0] out_cnt;
  logic [LAT:0]  tags;       // one bit per in-flight filter slot, tail aligns with filt_y
  logic          abort_act;
  logic          accept;

  assign abort_act = abort && (state == FLUSH || state == RUN || state == DRAIN);
  assign accept    = (state == RUN) && in_ready && in_valid && !abort;

  // Frame sequencer; all control outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      filt_x     <= '0;
      filt_rst_n <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      acc_cnt    <= '0;
      flush_cnt  <= '0;
      aborting   <= 1'b0;
    end else begin
      done   <= 1'b0;
      filt_x <= accept ? in_data : '0;
      if (abort_act) begin
        state      <= FLUSH;
        aborting   <= 1'b1;
        flush_cnt  <= '0;
        acc_cnt    <= '0;
        filt_rst_n <= 1'b0;
        in_ready   <= 1'b0;
        busy       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= FLUSH;
              aborting   <= 1'b0;
              flush_cnt  <= '0;
              acc_cnt    <= '0;
              filt_rst_n <= 1'b0;
              busy       <= 1'b1;
            end
          end
          FLUSH: begin
            if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
              filt_rst_n <= 1'b1;
              if (aborting) begin
                state    <= IDLE;
                aborting <= 1'b0;
                busy     <= 1'b0;
              end else begin
                state    <= RUN;
                in_ready <= 1'b1;
              end
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
          RUN: begin
            if (accept) begin
              acc_cnt <= acc_cnt + 1'b1;
              if (acc_cnt == CW'(FRAME_LEN - 1)) begin
                state    <= DRAIN;
                in_ready <= 1'b0;
              end
            end
          end
          DRAIN: begin
            if (tags == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  // Tag pipeline: bubbles shift in zeros so the tail tracks which filt_y is real.
  always_ff @(posedge clk) begin
    if (rst || abort_act) begin
      tags <= '0;
    end else begin
      tags[0] <= accept;
      for (int i = 1; i <= LAT; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  // Output stage: capture filt_y when the tail tag is set; data/last hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_cnt   <= '0;
    end else if (abort_act) begin
      out_valid <= 1'b0;
      out_cnt   <= '0;
    end else begin
      out_valid <= tags[LAT];
      if (tags[LAT]) begin
        out_data <= filt_y;
        out_last <= (out_cnt == CW'(FRAME_LEN - 1));
        out_cnt  <= out_cnt + 1'b1;
      end else if (state == IDLE && start) begin
        out_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_filter_ctrl.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for dsp_filter_ctrl with an identity filter of latency LAT.
// Latency : expected outputs are scheduled LAT+1 edges after each predicted accept.
// Backpr. : bench predicts in_ready from frame phase and only counts accepts in RUN.
module tb_dsp_filter_ctrl;

  localparam int N         = 7;
  localparam int LAT       = 1;
  localparam int FRAME_LEN = 4;
  localparam int FLUSH_LEN = 2;

  logic         clk = 1'b0;
  logic         rst, start, abort, in_valid;
  logic [N:0]   in_data, filt_x, filt_y, out_data;
  logic         in_ready, filt_rst_n, out_valid, out_last, busy, done;

  dsp_filter_ctrl #(.N(N), .LAT(LAT), .FRAME_LEN(FRAME_LEN), .FLUSH_LEN(FLUSH_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .filt_x(filt_x), .filt_rst_n(filt_rst_n), .filt_y(filt_y),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Identity filter, one register deep, cleared while held in reset.
  always @(posedge clk) filt_y <= filt_rst_n ? filt_x : '0;

  typedef struct {
    logic [N:0] d;
    bit         last;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  bit         tab_v[$];
  logic [N:0] tab_d[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         done_cnt = 0;
  bit         armed = 1'b0;
  logic [N:0] model_d = '0;
  bit         model_l = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output scoreboard: compares every edge, after the driver has updated the model.
  always begin
    exp_t it;
    @(posedge clk);
    #2;
    if (armed) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_out", 1, 0);
        end else begin
          it = exp_q.pop_front();
          chk("out_data", out_data, it.d);
          chk("out_last", out_last, it.last);
          chk("out_lat", cyc, it.due);
          model_d = it.d;
          model_l = it.last;
        end
      end else begin
        chk("hold_data", out_data, model_d);
        chk("hold_last", out_last, model_l);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          chk("missing_out", 0, 1);
          void'(exp_q.pop_front());
        end
      end
      if (done) done_cnt++;
    end
  end

  // mode 0: full frame, 1: abort after stop_n accepts, 2: reset after stop_n accepts
  task automatic frame(input int mode, input int stop_n, input bit use_tab);
    int         acc = 0;
    int         guard;
    int         d0 = done_cnt;
    bit         v;
    logic [N:0] d;

    chk("idle_rdy", in_ready, 0);
    start = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    tick();
    start = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < FLUSH_LEN; k++) begin
      chk("flush_rstn", filt_rst_n, 0);
      chk("flush_x", filt_x, 0);
      chk("flush_busy", busy, 1);
      chk("flush_rdy", in_ready, 0);
      tick();
    end
    chk("run_rstn", filt_rst_n, 1);

    guard = 0;
    while (acc < FRAME_LEN && guard < 200) begin
      guard++;
      chk("run_rdy", in_ready, 1);
      if (mode != 0 && acc == stop_n) break;
      if (use_tab && tab_v.size() > 0) begin
        v = tab_v.pop_front();
        d = v ? tab_d.pop_front() : 8'($urandom_range(1, 255));
      end else begin
        v = ($urandom_range(0, 9) < 7);
        d = 8'($urandom_range(0, 255));
      end
      start = ($urandom_range(0, 3) == 0);
      in_valid = v; in_data = d;
      if (v) begin
        acc++;
        exp_q.push_back('{d: d, last: (acc == FRAME_LEN), due: cyc + 1 + LAT + 1});
      end
      tick();
      chk("filt_x", filt_x, v ? d : 8'h00);
    end
    start = 1'b0; in_valid = 1'b0;

    if (mode == 0) begin
      chk("drain_rdy", in_ready, 0);
      guard = 0;
      while (busy && guard < 30) begin
        tick();
        guard++;
      end
      chk("end_idle", busy, 0);
      chk("exp_empty", exp_q.size(), 0);
      chk("done_once", done_cnt, d0 + 1);
    end else if (mode == 1) begin
      abort = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
      tick();
      abort = 1'b0; start = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      chk("ab_rdy", in_ready, 0);
      chk("ab_ov", out_valid, 0);
      chk("ab_x", filt_x, 0);
      for (int k = 0; k < FLUSH_LEN; k++) begin
        chk("ab_rstn", filt_rst_n, 0);
        chk("ab_busy", busy, 1);
        tick();
      end
      chk("ab_idle", busy, 0);
      chk("ab_rstn_hi", filt_rst_n, 1);
      for (int k = 0; k < 3; k++) tick();
      chk("ab_nodone", done_cnt, d0);
    end else begin
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h77;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      model_d = '0; model_l = 1'b0;
      chk("mr_rdy", in_ready, 0);
      chk("mr_x", filt_x, 0);
      chk("mr_rstn", filt_rst_n, 1);
      chk("mr_ov", out_valid, 0);
      chk("mr_od", out_data, 0);
      chk("mr_ol", out_last, 0);
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      for (int k = 0; k < 6; k++) tick();
      chk("mr_nolast", out_last, 0);
      chk("mr_nodone", done_cnt, d0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    tick();
    tick();
    chk("rst_rdy", in_ready, 0);
    chk("rst_x", filt_x, 0);
    chk("rst_rstn", filt_rst_n, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 0);
    chk("rst_ol", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    armed = 1'b1;

    // back-to-back frame, started on the first edge after reset
    tab_v = '{1, 1, 1, 1};
    tab_d = '{8'h01, 8'h02, 8'h03, 8'h04};
    frame(0, 0, 1'b1);

    // bubbles between samples
    tab_v = '{1, 0, 1, 1, 0, 1};
    tab_d = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    frame(0, 0, 1'b1);

    frame(1, 2, 1'b0);   // abort after two accepts
    frame(0, 0, 1'b0);   // normal frame afterwards
    frame(2, 3, 1'b0);   // reset mid-frame after three accepts
    frame(0, 0, 1'b0);

    for (int i = 0; i < 6; i++) frame(0, 0, 1'b0);
    for (int i = 0; i < 3; i++) frame(1, $urandom_range(0, FRAME_LEN - 1), 1'b0);
    frame(0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
